// File: rtl/alu_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// ADD/XOR/AND take one ALU cycle; LSH/RSH by k are issued as k single-bit shifts.
module alu_sequencer #(
   parameter int W   = 8,
   parameter int SHW = 3
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [3:0]     req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [3:0]     req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           alu_en,
   output logic [3:0]     alu_op,
   output logic [W-1:0]   alu_ina,
   output logic [W-1:0]   alu_inb,
   input  logic [W-1:0]   alu_out,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_data,
   output logic           rsp_err,
   output logic           busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_LSH = 4'b0100;
   localparam logic [3:0] OP_RSH = 4'b1101;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } reqT;

   logic [1:0]     state;
   logic           lastGrant;
   logic [SHW-1:0] count;
   reqT            cur;
   logic           curId;
   logic [W-1:0]   work;
   logic [W-1:0]   resData;
   logic           resErr;

   reqT            req0;
   reqT            req1;
   reqT            reqSel;
   logic           grantId;
   logic           accept;
   logic           isAlu;
   logic           isShift;
   logic [SHW-1:0] amount;

   assign req0 = '{op: req0_op, a: req0_a, b: req0_b};
   assign req1 = '{op: req1_op, a: req1_a, b: req1_b};

   // Contested grant goes opposite the last winner; a lone requester always wins.
   always_comb begin
      if (req0_valid && req1_valid) grantId = ~lastGrant;
      else                          grantId = ~req0_valid;
      reqSel  = grantId ? req1 : req0;
      accept  = Reset_n && (state == IDLE) && (req0_valid || req1_valid);
      isAlu   = (reqSel.op == OP_ADD) || (reqSel.op == OP_XOR) || (reqSel.op == OP_AND);
      isShift = (reqSel.op == OP_LSH) || (reqSel.op == OP_RSH);
      amount  = reqSel.b[SHW-1:0];
   end

   // Reset_n gating keeps ready low while reset is held, since IDLE is the reset state.
   assign req0_ready = accept & ~grantId;
   assign req1_ready = accept & grantId;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         lastGrant <= 1'b1;
         count     <= '0;
         cur       <= '0;
         curId     <= 1'b0;
         work      <= '0;
         resData   <= '0;
         resErr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cur       <= reqSel;
                  curId     <= grantId;
                  lastGrant <= grantId;
                  work      <= reqSel.a;
                  resErr    <= 1'b0;
                  if (isAlu) begin
                     state <= EXEC;
                  end else if (isShift) begin
                     if (amount != '0) begin
                        count <= amount;
                        state <= SHIFT;
                     end else begin
                        resData <= reqSel.a;
                        state   <= DONE;
                     end
                  end else begin
                     resData <= '0;
                     resErr  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            EXEC: begin
               resData <= alu_out;
               state   <= DONE;
            end
            SHIFT: begin
               work  <= alu_out;
               count <= count - 1'b1;
               if (count == SHW'(1)) begin
                  resData <= alu_out;
                  state   <= DONE;
               end
            end
            default: begin
               if (rsp_ready) state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      alu_en  = (state == EXEC) || (state == SHIFT);
      alu_op  = alu_en ? cur.op : 4'b0000;
      alu_ina = '0;
      alu_inb = '0;
      if (state == EXEC) begin
         alu_ina = cur.a;
         alu_inb = cur.b;
      end else if (state == SHIFT) begin
         alu_ina = work;
      end
   end

   // Response fields read as zero outside DONE so stale results never leak.
   assign rsp_valid = (state == DONE);
   assign rsp_id    = rsp_valid & curId;
   assign rsp_data  = rsp_valid ? resData : '0;
   assign rsp_err   = rsp_valid & resErr;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: transaction-level model checked every cycle,
// plus literal expectations on captured responses and ALU traffic.
module tb_alu_sequencer;
   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_op = '0, req1_op = '0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         alu_en;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_ina, alu_inb, alu_out;
   logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;
   logic [W-1:0] rsp_data;

   alu_sequencer #(.W(W), .SHW(3)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_en(alu_en), .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 Clk = ~Clk;

   function automatic logic [W-1:0] aluFn(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      case (op)
         4'b0000: return a + b;
         4'b0010: return a ^ b;
         4'b0011: return a & b;
         4'b0100: return a << 1;
         4'b1101: return a >> 1;
         default: return '0;
      endcase
   endfunction
   assign alu_out = aluFn(alu_op, alu_ina, alu_inb);

   typedef struct { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; } reqT;
   typedef struct { logic id; logic [W-1:0] data; logic err; } rspT;
   reqT q0[$];
   reqT q1[$];
   rspT rspLog[$];
   logic [W-1:0] inaLog[$];

   int nCmp = 0;
   int nFail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one request in flight, n ALU cycles, response after them.
   bit           mBusy = 0;
   bit           mExec = 0;
   int           mAge = 0, mN = 0;
   logic         mId = 1'b0, mLast = 1'b1, mErr = 1'b0;
   logic [3:0]   mOp = '0;
   logic [W-1:0] mA = '0, mB = '0, mRes = '0;
   logic         g, acc0, acc1;
   logic [2:0]   k;

   always @(posedge Clk) begin
      acc0 = 0;
      acc1 = 0;
      if (!Reset_n) begin
         mBusy = 0;
         mLast = 1'b1;
      end else if (!mBusy) begin
         if (req0_valid || req1_valid) begin
            if (req0_valid && req1_valid) g = ~mLast;
            else if (req0_valid)          g = 1'b0;
            else                          g = 1'b1;
            mOp = g ? req1_op : req0_op;
            mA  = g ? req1_a : req0_a;
            mB  = g ? req1_b : req0_b;
            k   = mB[2:0];
            mErr = 1'b0;
            mExec = 0;
            case (mOp)
               4'b0000: begin mRes = mA + mB; mN = 1; mExec = 1; end
               4'b0010: begin mRes = mA ^ mB; mN = 1; mExec = 1; end
               4'b0011: begin mRes = mA & mB; mN = 1; mExec = 1; end
               4'b0100: begin mRes = W'(mA << k); mN = int'(k); end
               4'b1101: begin mRes = mA >> k; mN = int'(k); end
               default: begin mRes = '0; mErr = 1'b1; mN = 0; end
            endcase
            mBusy = 1;
            mAge = 1;
            mId = g;
            mLast = g;
            if (g) acc1 = 1; else acc0 = 1;
         end
      end else if (mAge > mN && rsp_ready) begin
         mBusy = 0;
      end else begin
         mAge++;
      end
      #1;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      if (req0_valid) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
      else begin req0_op = '0; req0_a = '0; req0_b = '0; end
      if (req1_valid) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
      else begin req1_op = '0; req1_a = '0; req1_b = '0; end
   end

   logic         eR0, eR1, eEn, eV, cg;
   logic [3:0]   eOp;
   logic [W-1:0] eIna, eInb;

   always @(negedge Clk) begin
      if (!Reset_n) begin
         chk("reset_outputs",
             {req0_ready, req1_ready, alu_en, alu_op, alu_ina, alu_inb, rsp_valid, rsp_id, rsp_data, rsp_err, busy}, 64'd0);
      end else begin
         eR0 = 0; eR1 = 0; eEn = 0; eOp = '0; eIna = '0; eInb = '0; eV = 0;
         if (!mBusy) begin
            if (req0_valid && req1_valid) cg = ~mLast;
            else                          cg = ~req0_valid;
            eR0 = req0_valid && !cg;
            eR1 = req1_valid && cg;
         end else begin
            if (mAge >= 1 && mAge <= mN) begin
               eEn = 1;
               eOp = mOp;
               if (mExec) begin
                  eIna = mA;
                  eInb = mB;
               end else begin
                  eIna = (mOp == 4'b0100) ? W'(mA << (mAge - 1)) : W'(mA >> (mAge - 1));
               end
            end
            eV = (mAge > mN);
         end
         chk("req_ready", {req0_ready, req1_ready}, {eR0, eR1});
         chk("alu_bus", {alu_en, alu_op, alu_ina, alu_inb}, {eEn, eOp, eIna, eInb});
         chk("rsp_valid_busy", {rsp_valid, busy}, {eV, mBusy});
         if (eV) chk("rsp_fields", {rsp_id, rsp_err, rsp_data}, {mId, mErr, mRes});
         if (rsp_valid && rsp_ready) rspLog.push_back('{rsp_id, rsp_data, rsp_err});
         if (alu_en) inaLog.push_back(alu_ina);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic waitIdle();
      bit ok = 0;
      for (int i = 0; i < 80 && !ok; i++) begin
         cyc(1);
         ok = !mBusy && q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid;
      end
      chk("wait_idle_timeout", ok, 1);
   endtask

   task automatic clearLogs();
      rspLog.delete();
      inaLog.delete();
   endtask

   task automatic chkRsp(input string name, input int idx, input logic id, input logic [W-1:0] data, input logic err);
      if (idx < rspLog.size()) chk(name, {rspLog[idx].id, rspLog[idx].err, rspLog[idx].data}, {id, err, data});
      else chk({name, "_missing"}, rspLog.size(), idx + 1);
   endtask

   initial begin
      bit ok;
      #1;
      chk("reset_lit", {req0_ready, req1_ready, alu_en, rsp_valid, busy, rsp_data}, 64'd0);
      cyc(2);
      Reset_n = 1'b1;

      // ADD wraps: F0+20 = 10
      clearLogs();
      q0.push_back('{4'b0000, 8'hF0, 8'h20});
      waitIdle();
      chk("add_count", rspLog.size(), 1);
      chkRsp("add_rsp", 0, 1'b0, 8'h10, 1'b0);

      // LSH 81 by 3 from requester 1
      clearLogs();
      q1.push_back('{4'b0100, 8'h81, 8'h03});
      waitIdle();
      chk("lsh_alu_cycles", inaLog.size(), 3);
      if (inaLog.size() == 3) chk("lsh_ina_seq", {inaLog[0], inaLog[1], inaLog[2]}, {8'h81, 8'h02, 8'h04});
      chkRsp("lsh_rsp", 0, 1'b1, 8'h08, 1'b0);

      // contested: alternate 0,1,0,1
      clearLogs();
      q0.push_back('{4'b0010, 8'hAA, 8'h0F});
      q0.push_back('{4'b0010, 8'hAA, 8'h0F});
      q1.push_back('{4'b0011, 8'hF0, 8'h3C});
      q1.push_back('{4'b0011, 8'hF0, 8'h3C});
      waitIdle();
      chk("rr_count", rspLog.size(), 4);
      chkRsp("rr_0", 0, 1'b0, 8'hA5, 1'b0);
      chkRsp("rr_1", 1, 1'b1, 8'h30, 1'b0);
      chkRsp("rr_2", 2, 1'b0, 8'hA5, 1'b0);
      chkRsp("rr_3", 3, 1'b1, 8'h30, 1'b0);

      // shift by zero: no ALU use
      clearLogs();
      q0.push_back('{4'b1101, 8'h80, 8'h00});
      waitIdle();
      chk("rsh0_alu_cycles", inaLog.size(), 0);
      chkRsp("rsh0_rsp", 0, 1'b0, 8'h80, 1'b0);

      // illegal opcode
      clearLogs();
      q1.push_back('{4'b0111, 8'h55, 8'h33});
      waitIdle();
      chk("illegal_alu_cycles", inaLog.size(), 0);
      chkRsp("illegal_rsp", 0, 1'b1, 8'h00, 1'b1);

      // response backpressure with a second requester waiting
      clearLogs();
      rsp_ready = 1'b0;
      q0.push_back('{4'b0000, 8'h05, 8'h07});
      q1.push_back('{4'b0010, 8'h03, 8'h05});
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cyc(1);
         ok = rsp_valid;
      end
      chk("stall_wait_timeout", ok, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("stall_hold", {rsp_valid, busy, req0_ready, req1_ready, alu_en, rsp_id, rsp_err, rsp_data},
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C});
      end
      rsp_ready = 1'b1;
      waitIdle();
      chkRsp("stall_rsp0", 0, 1'b0, 8'h0C, 1'b0);
      chkRsp("stall_rsp1", 1, 1'b1, 8'h06, 1'b0);

      // reset in the middle of a 7-step shift
      clearLogs();
      q0.push_back('{4'b0100, 8'h01, 8'h07});
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cyc(1);
         ok = alu_en;
      end
      chk("shift_start_timeout", ok, 1);
      cyc(2);
      Reset_n = 1'b0;
      #1;
      chk("midreset_outputs",
          {req0_ready, req1_ready, alu_en, alu_op, alu_ina, alu_inb, rsp_valid, rsp_id, rsp_data, rsp_err, busy}, 64'd0);
      cyc(2);
      Reset_n = 1'b1;
      clearLogs();
      q0.push_back('{4'b0000, 8'h01, 8'h02});
      q1.push_back('{4'b0010, 8'h03, 8'h05});
      waitIdle();
      chk("post_reset_count", rspLog.size(), 2);
      chkRsp("post_reset_first", 0, 1'b0, 8'h03, 1'b0);
      chkRsp("post_reset_second", 1, 1'b1, 8'h06, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that shares the single combinational ALU between two requesters (fetch/decode path = requester 0, auxiliary path = requester 1). It arbitrates round-robin, issues ADD/XOR/AND as one ALU cycle, and expands LSH/RSH by N into N single-bit ALU shift cycles. It returns one tagged result per accepted request over a valid/ready response channel. It sits between the issue logic and the ALU and owns the ALU input bus exclusively.

## Interface
- W, 8, datapath width
- SHW, 3, shift-amount width; amount = b[SHW-1:0]
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  4  opcode: ADD 0000, XOR 0010, AND 0011, LSH 0100, RSH 1101
- req0_a / req1_a  in  W  operand A (shift source)
- req0_b / req1_b  in  W  operand B (shift amount in low SHW bits for LSH/RSH)
- alu_en  out  1  ALU inputs meaningful this cycle
- alu_op  out  4  opcode driven to ALU
- alu_ina / alu_inb  out  W  ALU operands
- alu_out  in  W  ALU combinational result (LSH/RSH shift alu_ina by exactly 1, zero-fill)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index of result
- rsp_data  out  W  result
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE: grant = round-robin among valid requesters; last-grant pointer resets to 1, so requester 0 wins the first contest. Only the granted requester sees reqN_ready=1; the other sees 0. On handshake, latch op, a, b, id; flip the pointer to id.
  - ADD/XOR/AND -> EXEC.
  - LSH/RSH with amount k>0 -> SHIFT, count=k. With k=0 -> DONE, data=a.
  - Any other opcode -> DONE, data=0, err=1.
- EXEC: alu_en=1, alu_op=op, alu_ina=a, alu_inb=b; capture alu_out into the result register; -> DONE.
- SHIFT: alu_en=1, alu_op=op, alu_ina=working register (initially a), alu_inb=0; working <= alu_out; count <= count-1. When count==1 this cycle, capture into the result register -> DONE.
- DONE: rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE. No new request is accepted in the DONE cycle, even if it is the handshake cycle.
- When alu_en=0: alu_op=0000, alu_ina=alu_inb=0.
- Arithmetic: ADD wraps modulo 2^W; no carry is reported. Shift amounts >= W iterate fully, and the result becomes 0.
- Requests held valid but not granted must stay stable; the sequencer does not sample them.

## Timing
- Reset (Reset_n low, async) forces: state IDLE, pointer=1, count=0. All outputs go to 0: req*_ready, alu_en, alu_op, alu_ina, alu_inb, rsp_valid, rsp_id, rsp_data, rsp_err, busy. req*_ready stays 0 during reset.
- Reset asserted mid-operation aborts the request; no response is produced for it.
- Handshake at edge T:
  - ADD/XOR/AND: EXEC in cycle T+1, rsp_valid from T+2.
  - Shift by k>0: SHIFT in cycles T+1..T+k, rsp_valid from T+k+1.
  - Shift by 0 or illegal opcode: rsp_valid from T+1.
- Throughput: at most one request in flight. After rsp handshake at edge R, the next request can be accepted at edge R+1 at the earliest.
- rsp_ready held low stalls indefinitely in DONE; the ALU stays idle (alu_en=0).
- Simultaneous valid on both requesters in IDLE: grant the requester opposite to the pointer. Two back-to-back contests alternate 0,1,0,1.

## Test plan
- Reset then req0 ADD a=8'hF0 b=8'h20 -> req0_ready in first IDLE cycle; rsp at T+2: data=8'h10, id=0, err=0.
- Both requesters valid continuously: req0 XOR 8'hAA^8'h0F, req1 AND 8'hF0&8'h3C, rsp_ready=1 -> responses alternate id 0 (8'hA5), 1 (8'h30), 0, 1.
- req1 LSH a=8'h81 b=3 -> alu_en high exactly 3 cycles; alu_ina sequence 8'h81, 8'h02, 8'h04; rsp_data=8'h08 at T+4.
- RSH a=8'h80 b=0 -> rsp at T+1 with data=8'h80 and alu_en never asserted. Op 4'b0111 -> rsp at T+1 with err=1, data=0.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, req*_ready=0, busy=1. Release -> IDLE next cycle.
- Pull Reset_n low during SHIFT (b=7) -> all outputs 0 immediately. After release, req0 wins the first contest and no stale response appears.
